// File: rtl/ifb_queue.sv
// Instruction fetch buffer: a circular FIFO of fetched words sitting between
// the fetch request/response logic and the instruction aligner. Request
// credits guarantee a slot for every issued fetch; after a flush, responses
// to requests issued before the flush are dropped.
module ifb_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_req_i,
    output logic        s_req_ok_o,
    input  logic        s_rsp_i,
    input  logic [31:0] s_rsp_data_i,
    input  logic [2:0]  s_rsp_ferr_i,
    input  logic        s_rsp_lpinv_i,
    input  logic [1:0]  s_rsp_pred_i,
    input  logic        s_stall_i,
    output logic [4:0]  s_info_o,
    output logic [31:0] s_instr_o,
    output logic [1:0]  s_pred_o,
    output logic        s_ovf_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // One spare count above MAX_OUT so a request issued alongside a flush
    // while the credit is exhausted cannot wrap the outstanding counter.
    localparam int OC_W  = $clog2(MAX_OUT + 2);
    localparam int SUM_W = CNT_W + OC_W;
    localparam int ENT_W = 38;

    // Entry layout: {pred[1:0], ferr[2:0], lpinv, data[31:0]}
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [OC_W-1:0]  out_cnt;
    logic [OC_W-1:0]  dis_cnt;
    logic             ovf;

    logic             empty;
    logic             full;
    logic             rsp_valid;
    logic             stray;
    logic             drop;
    logic             push_due;
    logic             pop;
    logic             overflow;
    logic             push;
    logic [SUM_W-1:0] credit_sum;

    // Decode this cycle's push/pop/drop/overflow events from registered state.
    always_comb begin
        empty      = (cnt == '0);
        full       = (cnt == CNT_W'(DEPTH));
        rsp_valid  = s_rsp_i & (out_cnt != '0);
        stray      = s_rsp_i & (out_cnt == '0);
        drop       = rsp_valid & (dis_cnt != '0);
        push_due   = rsp_valid & (dis_cnt == '0) & ~s_flush_i;
        pop        = ~empty & ~s_stall_i & ~s_flush_i;
        overflow   = push_due & full & ~pop;
        push       = push_due & ~overflow;
        credit_sum = SUM_W'(cnt) + SUM_W'(out_cnt);
        s_req_ok_o = (credit_sum < SUM_W'(DEPTH)) & (out_cnt < OC_W'(MAX_OUT)) & ~s_reset_i;
    end

    // Control state: pointers, occupancy, outstanding/discard counters, sticky overflow.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            out_cnt <= '0;
            dis_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            out_cnt <= out_cnt + OC_W'(s_req_i) - OC_W'(rsp_valid);
            if (overflow | stray) begin
                ovf <= 1'b1;
            end
            if (s_flush_i) begin
                // Everything currently outstanding belongs to the old stream.
                cnt     <= '0;
                rd_ptr  <= wr_ptr;
                dis_cnt <= out_cnt - OC_W'(rsp_valid);
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push & ~pop) begin
                    cnt <= cnt + CNT_W'(1);
                end else if (pop & ~push) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (drop) begin
                    dis_cnt <= dis_cnt - OC_W'(1);
                end
            end
        end
    end

    // Entry storage; data path is not reset, validity comes from cnt.
    always_ff @(posedge s_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_rsp_pred_i, s_rsp_ferr_i, s_rsp_lpinv_i, s_rsp_data_i};
        end
    end

    // Present the head entry in the aligner format, or the empty pattern.
    always_comb begin
        head      = mem[rd_ptr];
        s_info_o  = 5'b00011;
        s_instr_o = '0;
        s_pred_o  = '0;
        s_ovf_o   = ovf;
        if (!empty) begin
            s_info_o  = {head[35:33], head[32], 1'b0};
            s_instr_o = head[31:0];
            s_pred_o  = head[37:36];
        end
    end

endmodule

// File: tb/tb_ifb_queue.sv
// Self-checking bench for ifb_queue: a behavioural model with a queue of
// expected entries, compared against the DUT head each cycle.
module tb_ifb_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req;
    logic        req_ok;
    logic        rsp;
    logic [31:0] data;
    logic [2:0]  ferr;
    logic        lpinv;
    logic [1:0]  pred;
    logic        stall;
    logic [4:0]  info;
    logic [31:0] instr;
    logic [1:0]  pred_o;
    logic        ovf;

    int vectors     = 0;
    int miscompares = 0;

    logic [37:0] exp_q[$];
    int          mout;
    int          mdis;
    logic        movf;

    ifb_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .s_clk_i       (clk),
        .s_reset_i     (rst),
        .s_flush_i     (flush),
        .s_req_i       (req),
        .s_req_ok_o    (req_ok),
        .s_rsp_i       (rsp),
        .s_rsp_data_i  (data),
        .s_rsp_ferr_i  (ferr),
        .s_rsp_lpinv_i (lpinv),
        .s_rsp_pred_i  (pred),
        .s_stall_i     (stall),
        .s_info_o      (info),
        .s_instr_o     (instr),
        .s_pred_o      (pred_o),
        .s_ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Expected outputs derived from the model state.
    function automatic logic [4:0] m_info();
        if (exp_q.size() == 0) return 5'b00011;
        return {exp_q[0][35:33], exp_q[0][32], 1'b0};
    endfunction

    function automatic logic [31:0] m_instr();
        if (exp_q.size() == 0) return 32'h0;
        return exp_q[0][31:0];
    endfunction

    function automatic logic [1:0] m_pred();
        if (exp_q.size() == 0) return 2'b00;
        return exp_q[0][37:36];
    endfunction

    function automatic logic m_ok();
        return ((exp_q.size() + mout) < DEPTH) && (mout < MAX_OUT) && !rst;
    endfunction

    task automatic idle();
        req   = 1'b0;
        rsp   = 1'b0;
        flush = 1'b0;
        data  = 32'h0;
        ferr  = 3'b000;
        lpinv = 1'b0;
        pred  = 2'b00;
    endtask

    task automatic set_rsp(input logic [31:0] d, input logic [2:0] f, input logic l, input logic [1:0] p);
        rsp   = 1'b1;
        data  = d;
        ferr  = f;
        lpinv = l;
        pred  = p;
    endtask

    // Advance one clock, updating the model with the inputs applied this cycle.
    task automatic tick();
        bit rv, pop_m, due, full_m;
        @(posedge clk);
        if (!rst) begin
            rv     = rsp && (mout > 0);
            full_m = (exp_q.size() == DEPTH);
            pop_m  = (exp_q.size() > 0) && !stall && !flush;
            due    = rv && (mdis == 0) && !flush;
            if ((rsp && mout == 0) || (due && full_m && !pop_m)) movf = 1'b1;
            if (flush) begin
                exp_q.delete();
                mdis = mout - int'(rv);
            end else begin
                if (pop_m) void'(exp_q.pop_front());
                if (due && !(full_m && !pop_m)) exp_q.push_back({pred, ferr, lpinv, data});
                if (rv && mdis > 0) mdis--;
            end
            mout = mout + int'(req) - int'(rv);
        end
        #1;
    endtask

    task automatic fill_quiet();
        stall = 1'b1;
        for (int c = 0; c < 7; c++) begin
            idle();
            req = m_ok();
            if (mout > 0) set_rsp($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (info !== 5'b00011 || instr !== 32'h0 || pred_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_outputs: got info=%b instr=%h pred=%b want 00011/0/0", info, instr, pred_o);
        end
        vectors++;
        if (req_ok !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ok_ovf: got req_ok=%b ovf=%b want 0/0", req_ok, ovf);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ok: got %b want 1", req_ok);
        end
        tick();
    endtask

    task automatic test_single();
        stall = 1'b0;
        idle();
        req = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ok !== m_ok()) begin
            miscompares++;
            $display("FAIL single_ok_req: got %b want %b", req_ok, m_ok());
        end
        tick();
        idle();
        set_rsp(32'h00B5_0513, 3'b000, 1'b0, 2'b00);
        @(negedge clk);
        vectors++;
        if (req_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ok_rsp: got %b want 1", req_ok);
        end
        tick();
        idle();
        @(negedge clk);
        vectors++;
        if (info !== 5'b00000 || instr !== 32'h00B5_0513 || info !== m_info() || instr !== m_instr()) begin
            miscompares++;
            $display("FAIL single_head: got info=%b instr=%h want 00000/00b50513", info, instr);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (info !== 5'b00011 || req_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL single_drained: got info=%b req_ok=%b want 00011/1", info, req_ok);
        end
        tick();
    endtask

    task automatic test_fill();
        stall = 1'b1;
        for (int c = 0; c < 7; c++) begin
            idle();
            req = m_ok();
            if (mout > 0) set_rsp($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            @(negedge clk);
            vectors++;
            if (req_ok !== m_ok() || ovf !== movf) begin
                miscompares++;
                $display("FAIL fill_credit c%0d: got req_ok=%b ovf=%b want %b/%b", c, req_ok, ovf, m_ok(), movf);
            end
            vectors++;
            if (info !== m_info() || instr !== m_instr() || pred_o !== m_pred()) begin
                miscompares++;
                $display("FAIL fill_head c%0d: got %b/%h/%b want %b/%h/%b", c, info, instr, pred_o, m_info(), m_instr(), m_pred());
            end
            tick();
        end
        idle();
        stall = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ok !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got req_ok=%b ovf=%b want 0/0", req_ok, ovf);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (info !== m_info() || instr !== m_instr() || pred_o !== m_pred()) begin
                miscompares++;
                $display("FAIL drain_head p%0d: got %b/%h/%b want %b/%h/%b", c, info, instr, pred_o, m_info(), m_instr(), m_pred());
            end
            tick();
        end
        vectors++;
        if (info !== 5'b00011) begin
            miscompares++;
            $display("FAIL drain_empty: got info=%b want 00011", info);
        end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int c = 0; c < 8; c++) begin
            idle();
            case (c)
                0: req = 1'b1;
                1: begin req = 1'b1; set_rsp(32'hAAAA_0001, 3'b001, 1'b0, 2'b01); end
                2: req = 1'b1;
                3: begin req = 1'b1; flush = 1'b1; end
                4: set_rsp(32'hDEAD_0001, 3'b000, 1'b0, 2'b00);
                5: set_rsp(32'hDEAD_0002, 3'b000, 1'b0, 2'b00);
                6: set_rsp(32'hBBBB_0003, 3'b000, 1'b0, 2'b11);
                default: ;
            endcase
            @(negedge clk);
            vectors++;
            if (req_ok !== m_ok() || info !== m_info() || instr !== m_instr() || pred_o !== m_pred()) begin
                miscompares++;
                $display("FAIL flush c%0d: got ok=%b %b/%h/%b want ok=%b %b/%h/%b", c, req_ok, info, instr, pred_o, m_ok(), m_info(), m_instr(), m_pred());
            end
            if (c == 7) begin
                vectors++;
                if (info[0] !== 1'b0 || instr !== 32'hBBBB_0003) begin
                    miscompares++;
                    $display("FAIL flush_third_head: got info=%b instr=%h want empty=0 bbbb0003", info, instr);
                end
            end
            tick();
        end
        idle();
        stall = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (info !== 5'b00011 || req_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_drained: got info=%b ok=%b want 00011/1", info, req_ok);
        end
        tick();
    endtask

    task automatic test_pred_lpinv();
        stall = 1'b0;
        idle();
        req = 1'b1;
        tick();
        idle();
        set_rsp(32'h1234_5678, 3'b010, 1'b1, 2'b10);
        tick();
        idle();
        @(negedge clk);
        vectors++;
        if (info !== 5'b01010 || pred_o !== 2'b10 || instr !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL lpinv_head: got info=%b pred=%b instr=%h want 01010/10/12345678", info, pred_o, instr);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (info !== m_info()) begin
            miscompares++;
            $display("FAIL lpinv_pop: got info=%b want %b", info, m_info());
        end
        tick();
    endtask

    task automatic test_overflow();
        fill_quiet();
        idle();
        req = 1'b1;
        tick();
        idle();
        set_rsp(32'hFFFF_EEEE, 3'b111, 1'b1, 2'b11);
        tick();
        idle();
        @(negedge clk);
        vectors++;
        if (ovf !== 1'b1 || movf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %b want 1", ovf);
        end
        stall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (info !== m_info() || instr !== m_instr() || pred_o !== m_pred()) begin
                miscompares++;
                $display("FAIL ovf_drain p%0d: got %b/%h/%b want %b/%h/%b", c, info, instr, pred_o, m_info(), m_instr(), m_pred());
            end
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky_flush: got %b want 1", ovf);
        end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_reset_clear: got %b want 0", ovf);
        end
        exp_q.delete();
        mout = 0;
        mdis = 0;
        movf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stray();
        stall = 1'b0;
        idle();
        set_rsp(32'h5555_5555, 3'b000, 1'b0, 2'b00);
        tick();
        idle();
        @(negedge clk);
        vectors++;
        if (ovf !== 1'b1 || info !== 5'b00011 || req_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_rsp: got ovf=%b info=%b ok=%b want 1/00011/1", ovf, info, req_ok);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle();
            req = 1'b1;
            if (c > 0) set_rsp(32'hC0DE_0000 + c, 3'b000, 1'b0, 2'b01);
            tick();
        end
        idle();
        @(negedge clk);
        vectors++;
        if (req_ok !== 1'b0 || info !== m_info() || instr !== m_instr()) begin
            miscompares++;
            $display("FAIL mid_before: got ok=%b info=%b instr=%h want 0/%b/%h", req_ok, info, instr, m_info(), m_instr());
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (info !== 5'b00011 || instr !== 32'h0 || pred_o !== 2'b00 || req_ok !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got %b/%h/%b ok=%b ovf=%b want 00011/0/0 ok=0 ovf=0", info, instr, pred_o, req_ok, ovf);
        end
        exp_q.delete();
        mout = 0;
        mdis = 0;
        movf = 1'b0;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idle();
            req = (c < 2);
            @(negedge clk);
            vectors++;
            if (req_ok !== m_ok() || info !== 5'b00011) begin
                miscompares++;
                $display("FAIL mid_after c%0d: got ok=%b info=%b want %b/00011", c, req_ok, info, m_ok());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        idle();
        exp_q.delete();
        mout = 0;
        mdis = 0;
        movf = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_flush();
        test_pred_lpinv();
        test_overflow();
        test_stray();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
